mean_div: RTL

MEAN_DIV -- requirements
Module: mean_div

---
 rtl/mean_div_pkg.sv | 13 +
 rtl/mean_div_step.sv | 29 ++
 rtl/mean_div.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mean_div_pkg.sv
// Shared defaults and FSM state encoding for the mean_div sequential divider.
package mean_div_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/mean_div_step.sv
// One combinational restoring shift-subtract iteration of the mean_div divider.
module mean_div_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W:0]   i_part,
  input  logic [DATA_W-1:0] i_quo,
  input  logic [DATA_W-1:0] i_dvs,
  output logic [DATA_W:0]   o_part,
  output logic [DATA_W-1:0] o_quo
);

  localparam int unsigned PART_W = DATA_W + 1;

  logic [DATA_W+1:0] w_shift;
  logic              w_ge;

  always_comb begin
    w_shift = {i_part, i_quo[DATA_W-1]};
    w_ge    = (w_shift >= {2'b00, i_dvs});
    if (w_ge) begin
      o_part = PART_W'(w_shift - {2'b00, i_dvs});
      o_quo  = {i_quo[DATA_W-2:0], 1'b1};
    end else begin
      o_part = w_shift[DATA_W:0];
      o_quo  = {i_quo[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mean_div.sv
// Multi-cycle mean divider: y = x / cnt, one quotient bit per clock.
// Defining MEAN_DIV_SIGNED_EN treats x as two's complement (sign-magnitude around the core).
module mean_div
  import mean_div_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] x,
  input  logic [CNT_W-1:0]  cnt,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] y,
  output logic [DATA_W-1:0] rem,
  output logic              div0
);

  localparam int unsigned       ITER_W    = $clog2(DATA_W);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(DATA_W - 1);

  state_e              r_state;
  logic [ITER_W-1:0]   r_iter;
  logic [DATA_W:0]     r_part;
  logic [DATA_W-1:0]   r_quo;
  logic [DATA_W-1:0]   r_dvs;
  logic                r_zero;
  logic                r_busy;
  logic                r_done;
  logic                r_div0;
  logic [DATA_W-1:0]   r_y;
  logic [DATA_W-1:0]   r_rem;

  logic [DATA_W:0]     w_part_nxt;
  logic [DATA_W-1:0]   w_quo_nxt;
  logic [DATA_W-1:0]   w_mag;
  logic [DATA_W-1:0]   w_y;
  logic [DATA_W-1:0]   w_rem;
  logic [DATA_W-1:0]   w_rem_mag;

  mean_div_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .i_part (r_part),
    .i_quo  (r_quo),
    .i_dvs  (r_dvs),
    .o_part (w_part_nxt),
    .o_quo  (w_quo_nxt)
  );

  // On divide-by-zero no iterations run, so r_quo still holds the captured dividend.
  assign w_rem_mag = r_zero ? r_quo : r_part[DATA_W-1:0];

`ifdef MEAN_DIV_SIGNED_EN
  logic r_neg;

  assign w_mag = x[DATA_W-1] ? -x : x;
  assign w_y   = r_zero ? '1 : (r_neg ? -r_quo : r_quo);
  assign w_rem = r_neg ? -w_rem_mag : w_rem_mag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_neg <= 1'b0;
    end else if (r_state == IDLE && en) begin
      r_neg <= x[DATA_W-1];
    end
  end
`else
  assign w_mag = x;
  assign w_y   = r_zero ? '1 : r_quo;
  assign w_rem = w_rem_mag;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_iter  <= '0;
      r_part  <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_zero  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_div0  <= 1'b0;
      r_y     <= '0;
      r_rem   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (en) begin
            r_busy  <= 1'b1;
            r_quo   <= w_mag;
            r_part  <= '0;
            r_dvs   <= DATA_W'(cnt);
            r_iter  <= '0;
            r_zero  <= (cnt == '0);
            r_state <= (cnt == '0) ? FIN : CALC;
          end
        end
        CALC: begin
          r_part <= w_part_nxt;
          r_quo  <= w_quo_nxt;
          r_iter <= r_iter + ITER_W'(1);
          if (r_iter == LAST_ITER) begin
            r_state <= FIN;
          end
        end
        FIN: begin
          r_y     <= w_y;
          r_rem   <= w_rem;
          r_div0  <= r_zero;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign y    = r_y;
  assign rem  = r_rem;
  assign div0 = r_div0;

endmodule
